// File: rtl/accel_sequencer.sv
// Polls a 3-axis accelerometer through a downstream I2C master: a one-time wake
// write, then a repeating pointer-set / 6-byte burst read loop with retry on timeout.
module accel_sequencer #(
  parameter logic [6:0] DEV_ADDR   = 7'h68,
  parameter int         SAMPLE_DIV = 100000,
  parameter int         TIMEOUT    = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [6:0]  deviceAddr_d,
  output logic [7:0]  regAddr_d,
  output logic [2:0]  numBytes_d,
  output logic [47:0] dataIn_d,
  output logic        write_d,
  output logic        start,
  output logic        driverDisable,
  input  logic        done,
  input  logic [47:0] dataOut,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic [7:0]  err_count,
  output logic        busy
);

  typedef enum logic [2:0] {
    OFF, INIT, INIT_W, PTR, PTR_W, READ, READ_W, GAP
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] GAP_LAST   = 32'(SAMPLE_DIV - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] timer_reg;
  logic [31:0] gap_reg;
  logic        timeout;
  logic        in_wait;
  logic        next_wait;

  assign in_wait   = (state_reg == INIT_W) || (state_reg == PTR_W) || (state_reg == READ_W);
  assign next_wait = (state_next == INIT_W) || (state_next == PTR_W) || (state_next == READ_W);
  assign start     = 1'b0;
  assign busy      = (state_reg != OFF);

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      OFF:  if (enable) state_next = INIT;
      INIT: state_next = INIT_W;
      PTR:  state_next = PTR_W;
      READ: state_next = READ_W;
      INIT_W, PTR_W, READ_W: begin
        // done beats a coincident timeout; a dropped enable ends the run after this transaction
        if (done) begin
          if (!enable) begin
            state_next = OFF;
          end else begin
            case (state_reg)
              INIT_W:  state_next = PTR;
              PTR_W:   state_next = READ;
              default: state_next = GAP;
            endcase
          end
        end else if (timer_reg == TIMER_LAST) begin
          timeout = 1'b1;
          if (!enable) begin
            state_next = OFF;
          end else begin
            case (state_reg)
              INIT_W:  state_next = INIT;
              PTR_W:   state_next = PTR;
              default: state_next = READ;
            endcase
          end
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) state_next = enable ? PTR : OFF;
      end
      default: state_next = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= OFF;
      driverDisable <= 1'b1;
      timer_reg     <= '0;
      gap_reg       <= '0;
      deviceAddr_d  <= '0;
      regAddr_d     <= '0;
      numBytes_d    <= '0;
      dataIn_d      <= '0;
      write_d       <= 1'b0;
      accel_x       <= '0;
      accel_y       <= '0;
      accel_z       <= '0;
      sample_valid  <= 1'b0;
      err_count     <= '0;
    end else begin
      state_reg <= state_next;
      // Registered from the next state so the master is released only while waiting
      driverDisable <= !next_wait;
      timer_reg     <= (in_wait && state_next == state_reg) ? timer_reg + 16'd1 : '0;
      gap_reg       <= (state_reg == GAP && state_next == GAP) ? gap_reg + 32'd1 : '0;

      case (state_next)
        INIT: begin
          deviceAddr_d <= DEV_ADDR;
          regAddr_d    <= 8'h6B;
          numBytes_d   <= 3'd1;
          dataIn_d     <= '0;
          write_d      <= 1'b1;
        end
        PTR: begin
          deviceAddr_d <= DEV_ADDR;
          regAddr_d    <= 8'h3B;
          numBytes_d   <= 3'd0;
          dataIn_d     <= '0;
          write_d      <= 1'b1;
        end
        READ: begin
          deviceAddr_d <= DEV_ADDR;
          regAddr_d    <= 8'h3B;
          numBytes_d   <= 3'd6;
          dataIn_d     <= '0;
          write_d      <= 1'b0;
        end
        default: ;
      endcase

      sample_valid <= (state_reg == READ_W) && done;
      if (state_reg == READ_W && done) begin
        accel_x <= {dataOut[7:0],   dataOut[15:8]};
        accel_y <= {dataOut[23:16], dataOut[31:24]};
        accel_z <= {dataOut[39:32], dataOut[47:40]};
      end

      if (timeout && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_accel_sequencer.sv
// Directed bench: instance A (long timeout) exercises the polling loop, instance B
// (TIMEOUT=50) exercises timeout retry, saturation and done/timeout collision.
module tb_accel_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, done_a;
  logic [47:0] dout_a;
  logic [6:0]  dev_a;
  logic [7:0]  reg_a;
  logic [2:0]  nb_a;
  logic [47:0] din_a;
  logic        wr_a, st_a, dd_a, sv_a, busy_a;
  logic [15:0] ax_a, ay_a, az_a;
  logic [7:0]  err_a;

  logic        rst_b, en_b, done_b;
  logic [47:0] dout_b;
  logic [6:0]  dev_b;
  logic [7:0]  reg_b;
  logic [2:0]  nb_b;
  logic [47:0] din_b;
  logic        wr_b, st_b, dd_b, sv_b, busy_b;
  logic [15:0] ax_b, ay_b, az_b;
  logic [7:0]  err_b;

  accel_sequencer #(.DEV_ADDR(7'h68), .SAMPLE_DIV(10), .TIMEOUT(400)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a),
    .deviceAddr_d(dev_a), .regAddr_d(reg_a), .numBytes_d(nb_a), .dataIn_d(din_a),
    .write_d(wr_a), .start(st_a), .driverDisable(dd_a), .done(done_a), .dataOut(dout_a),
    .accel_x(ax_a), .accel_y(ay_a), .accel_z(az_a), .sample_valid(sv_a),
    .err_count(err_a), .busy(busy_a)
  );

  accel_sequencer #(.DEV_ADDR(7'h68), .SAMPLE_DIV(10), .TIMEOUT(50)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b),
    .deviceAddr_d(dev_b), .regAddr_d(reg_b), .numBytes_d(nb_b), .dataIn_d(din_b),
    .write_d(wr_b), .start(st_b), .driverDisable(dd_b), .done(done_b), .dataOut(dout_b),
    .accel_x(ax_b), .accel_y(ay_b), .accel_z(az_b), .sample_valid(sv_b),
    .err_count(err_b), .busy(busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_low_a();
    for (int i = 0; i < 5000 && dd_a; i++) tick();
    check("a_wait_state_reached", dd_a, 1'b0);
  endtask

  task automatic wait_low_b();
    for (int i = 0; i < 5000 && dd_b; i++) tick();
    check("b_wait_state_reached", dd_b, 1'b0);
  endtask

  // Behaves like the I2C master: answers the pending command with done after lat wait cycles
  task automatic do_txn_a(input int lat, input logic drop,
                          output logic [7:0] ra, output logic [2:0] nb, output logic w);
    wait_low_a();
    ra = reg_a;
    nb = nb_a;
    w  = wr_a;
    check("a_dev_addr", dev_a, 7'h68);
    if (drop) en_a = 1'b0;
    repeat (lat - 1) tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    $display("txn A: reg=%02h nb=%0d wr=%0d", ra, nb, w);
  endtask

  logic [7:0] ra;
  logic [2:0] nb;
  logic       w;
  int gap, svc, lows;

  initial begin
    rst_a = 1'b0; en_a = 1'b1; done_a = 1'b0; dout_a = '0;
    rst_b = 1'b0; en_b = 1'b0; done_b = 1'b0; dout_b = '0;
    repeat (3) tick();

    // Reset state with enable already high
    check("rst_dd", dd_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_dev", dev_a, 7'h00);
    check("rst_reg", reg_a, 8'h00);
    check("rst_nb", nb_a, 3'd0);
    check("rst_wr", wr_a, 1'b0);
    check("rst_start", st_a, 1'b0);
    check("rst_ax", ax_a, 16'h0);
    check("rst_sv", sv_a, 1'b0);
    check("rst_err", err_a, 8'h0);
    rst_a = 1'b1;
    tick();
    check("init_reg", reg_a, 8'h6B);
    check("init_wr", wr_a, 1'b1);
    check("init_nb", nb_a, 3'd1);
    check("init_dd", dd_a, 1'b1);
    check("init_busy", busy_a, 1'b1);
    $display("txn A: reset released, INIT issued");

    // Full INIT / PTR / READ cycle
    dout_a = {8'h01, 8'h00, 8'h80, 8'hFF, 8'h34, 8'h12};
    do_txn_a(300, 1'b0, ra, nb, w);
    check("c1_reg", ra, 8'h6B); check("c1_nb", nb, 3'd1); check("c1_wr", w, 1'b1);
    do_txn_a(300, 1'b0, ra, nb, w);
    check("c2_reg", ra, 8'h3B); check("c2_nb", nb, 3'd0); check("c2_wr", w, 1'b1);
    do_txn_a(300, 1'b0, ra, nb, w);
    check("c3_reg", ra, 8'h3B); check("c3_nb", nb, 3'd6); check("c3_wr", w, 1'b0);
    check("sv_pulse", sv_a, 1'b1);
    check("accel_x", ax_a, 16'h1234);
    check("accel_y", ay_a, 16'hFF80);
    check("accel_z", az_a, 16'h0001);

    // GAP length: READ fields stay on the bus with driverDisable high until the PTR command
    gap = 0; svc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!dd_a) break;
      if (nb_a == 3'd6) gap++;
      if (sv_a) svc++;
      tick();
    end
    check("gap_cycles", gap, 10);
    check("sv_count", svc, 1);
    check("gap_next_reg", reg_a, 8'h3B);
    check("gap_next_nb", nb_a, 3'd0);
    $display("txn A: gap=%0d sample_valid pulses=%0d", gap, svc);

    // Finish PTR, then drop enable during READ_W
    do_txn_a(20, 1'b0, ra, nb, w);
    check("p2_nb", nb, 3'd0);
    dout_a = {8'h00, 8'h80, 8'h02, 8'h01, 8'hCD, 8'hAB};
    do_txn_a(300, 1'b1, ra, nb, w);
    check("drop_nb", nb, 3'd6);
    check("drop_sv", sv_a, 1'b1);
    check("drop_ax", ax_a, 16'hABCD);
    check("drop_ay", ay_a, 16'h0102);
    check("drop_az", az_a, 16'h8000);
    check("drop_busy", busy_a, 1'b0);
    tick();
    check("drop_sv_off", sv_a, 1'b0);
    check("drop_dd", dd_a, 1'b1);

    // done while OFF is ignored and samples hold
    dout_a = 48'hFFFF_FFFF_FFFF;
    done_a = 1'b1; tick(); done_a = 1'b0; tick();
    check("off_done_ax", ax_a, 16'hABCD);
    check("off_done_sv", sv_a, 1'b0);
    check("off_done_busy", busy_a, 1'b0);

    // Re-enable restarts at INIT, then an asynchronous reset mid-transaction
    en_a = 1'b1;
    tick();
    check("reen_reg", reg_a, 8'h6B);
    check("reen_nb", nb_a, 3'd1);
    wait_low_a();
    repeat (5) tick();
    rst_a = 1'b0;
    #1;
    check("async_busy", busy_a, 1'b0);
    check("async_dd", dd_a, 1'b1);
    check("async_ax", ax_a, 16'h0);
    tick();
    rst_a = 1'b1;
    tick();
    check("rerst_reg", reg_a, 8'h6B);
    check("rerst_wr", wr_a, 1'b1);
    $display("txn A: async reset mid-transaction, INIT reissued");

    // Timeout behaviour on instance B
    rst_b = 1'b1; en_b = 1'b1;
    wait_low_b();
    repeat (4) tick();
    done_b = 1'b1; tick(); done_b = 1'b0;
    wait_low_b();
    check("b_ptr_nb", nb_b, 3'd0);
    lows = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (dd_b) break;
      lows++;
    end
    check("b_timeout_cycles", lows, 50);
    check("b_err1", err_b, 8'd1);
    check("b_retry_reg", reg_b, 8'h3B);
    check("b_retry_nb", nb_b, 3'd0);
    check("b_retry_wr", wr_b, 1'b1);
    tick();
    check("b_dd_pulse_len", dd_b, 1'b0);
    $display("txn B: PTR timed out after %0d cycles, err=%0d", lows, err_b);

    // done on the very cycle the timer expires
    repeat (49) tick();
    done_b = 1'b1; tick(); done_b = 1'b0;
    check("b_coinc_nb", nb_b, 3'd6);
    check("b_coinc_wr", wr_b, 1'b0);
    check("b_coinc_err", err_b, 8'd1);
    $display("txn B: done on timeout cycle, err=%0d", err_b);

    // READ never answered: error count saturates
    for (int i = 0; i < 20000 && err_b != 8'hFF; i++) tick();
    check("b_err_sat", err_b, 8'hFF);
    repeat (120) tick();
    check("b_err_hold", err_b, 8'hFF);
    check("b_busy", busy_b, 1'b1);
    $display("txn B: err_count=%0d after repeated timeouts", err_b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_sequencer.md
ACCEL_SEQUENCER -- requirements
Module: accel_sequencer

Interface
REQ-001 Parameter DEV_ADDR, default 7'h68; 7-bit I2C address of the accelerometer.
REQ-002 Parameter SAMPLE_DIV, default 100000; clk cycles from one read command's completion to the next pointer-set command.
REQ-003 Parameter TIMEOUT, default 20000; maximum clk cycles to wait for a transaction to complete.
REQ-004 clk  in  1  shared clock; same clock as the downstream I2C master.
REQ-005 rst  in  1  reset; asynchronous, active-low.
REQ-006 enable  in  1  high permits polling.
REQ-007 deviceAddr_d  out  7  I2C device address command field.
REQ-008 regAddr_d  out  8  I2C register address command field.
REQ-009 numBytes_d  out  3  I2C payload byte count.
REQ-010 dataIn_d  out  8x6  I2C write payload.
REQ-011 write_d  out  1  I2C write (1) or read (0).
REQ-012 start  out  1  tied 0; the master self-starts from its idle delay.
REQ-013 driverDisable  out  1  holds the I2C master in its idle/reset condition.
REQ-014 done  in  1  one-cycle pulse from the master at transaction end.
REQ-015 dataOut  in  8x6  I2C read bytes; stable while done is high.
REQ-016 accel_x, accel_y, accel_z  out  16 each  signed samples.
REQ-017 sample_valid  out  1  one-cycle pulse when new samples land.
REQ-018 err_count  out  8  saturating timeout count.
REQ-019 busy  out  1  high in any state other than OFF.

Function
REQ-020 States: OFF, INIT, INIT_W, PTR, PTR_W, READ, READ_W, GAP.
REQ-021 Command states last 1 cycle: load command fields; driverDisable=1.
REQ-022 Wait states (_W): driverDisable=0; command fields held constant.
REQ-023 OFF -> INIT when enable=1; otherwise remain in OFF with driverDisable=1.
REQ-024 INIT command: write_d=1, regAddr_d=8'h6B, numBytes_d=1, dataIn_d[0]=8'h00, others 0.
REQ-025 PTR command: write_d=1, regAddr_d=8'h3B, numBytes_d=0.
REQ-026 READ command: write_d=0, numBytes_d=6, regAddr_d=8'h3B.
REQ-027 deviceAddr_d=DEV_ADDR in every command state.
REQ-028 Sequencing on done in a wait state: INIT_W->PTR, PTR_W->READ, READ_W->GAP.
REQ-029 On that done cycle, driverDisable is registered to 1, so the master is disabled before its next negedge sample.
REQ-030 READ_W on done: accel_x={dataOut[0],dataOut[1]}, accel_y={dataOut[2],dataOut[3]}, accel_z={dataOut[4],dataOut[5]}; sample_valid=1 the following cycle, exactly one cycle.
REQ-031 GAP: counter counts 0..SAMPLE_DIV-1; driverDisable=1. At the terminal count, go to PTR if enable=1, else OFF.
REQ-032 Wait timer is a 16-bit counter cleared on entry to each wait state; driverDisable=1 for one cycle when it reaches TIMEOUT.
REQ-033 On timeout: err_count increments, saturating at 255; the same command state is re-entered (retry).
REQ-034 done and timeout in the same cycle: done wins, no error counted.
REQ-035 enable=0 during a wait state: the transaction completes, and the machine then returns to OFF instead of continuing.
REQ-036 done while in OFF, GAP or a command state is ignored.
REQ-037 Sample registers hold their value until the next successful read.

Reset
REQ-038 rst=0 asynchronously forces: state=OFF, driverDisable=1, start=0, all command fields 0, accel_x/y/z=0, sample_valid=0, err_count=0, counters 0.
REQ-039 Reset mid-transaction abandons the transaction; after release, the sequence restarts at INIT once enable=1.

Verification
REQ-040 Reset: rst=0 with enable=1 -> driverDisable=1, busy=0, all outputs 0; rst=1 -> INIT command (regAddr_d=8'h6B, write_d=1, numBytes_d=1) within 2 cycles.
REQ-041 Full cycle (done pulses injected 300 cycles after each command): command order INIT, PTR, READ; dataOut={12,34,FF,80,00,01}h -> accel_x=16'h1234, accel_y=16'hFF80, accel_z=16'h0001, one sample_valid pulse.
REQ-042 Timeout: TIMEOUT=50, no done in PTR_W -> driverDisable pulse at cycle 50, err_count=1, PTR command reissued; 300 timeouts -> err_count=255.
REQ-043 Period: SAMPLE_DIV=10 -> exactly 10 GAP cycles between READ_W done and the next PTR command.
REQ-044 enable dropped in READ_W -> samples still update on done, then OFF, busy=0; re-enable -> INIT.
REQ-045 done coinciding with the timeout cycle -> sequence advances, err_count unchanged.
